// File: rtl/ret_addr_stack_pkg.sv
// Shared sizes and the checkpoint record type for the return-address stack.
package ret_addr_stack_pkg;

    localparam int RAS_DEPTH  = 16;
    localparam int RAS_CKPT_N = 8;
    localparam int IP_WIDTH   = 48;
    localparam int RAS_TOS_W  = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W  = RAS_TOS_W + 1;

    // Snapshot of the stack head; deeper entries are shared with the live ring.
    typedef struct packed {
        logic [RAS_TOS_W-1:0] tos;
        logic [RAS_CNT_W-1:0] count;
        logic [IP_WIDTH-1:0]  top_ip;
    } ras_ckpt_t;

endpackage

// File: rtl/ret_addr_stack_ckpt_table.sv
// Checkpoint slot table: one synchronous write port, one asynchronous read port.
module ras_ckpt_table
    import ret_addr_stack_pkg::*;
#(
    parameter int CKPT_N = RAS_CKPT_N,
    parameter int TAG_W  = $clog2(CKPT_N)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [TAG_W-1:0] wrTag,
    input  ras_ckpt_t        wrData,
    input  logic [TAG_W-1:0] rdTag,
    output ras_ckpt_t        rdData
);

    ras_ckpt_t slots [CKPT_N];

    // Slots are not reset; a same-edge read sees the value before this write.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            slots[wrTag] <= wrData;
        end
    end

    assign rdData = slots[rdTag];

endmodule

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with 1-cycle registered pop prediction.
// Optional mispredict checkpoints are enabled by defining RAS_CHECKPOINT_EN.
module ret_addr_stack #(
    parameter int DEPTH    = ret_addr_stack_pkg::RAS_DEPTH,
    parameter int IP_WIDTH = ret_addr_stack_pkg::IP_WIDTH,
    parameter int CKPT_N   = ret_addr_stack_pkg::RAS_CKPT_N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_en,
    input  logic                      pop_en,
    input  logic [IP_WIDTH-1:0]       push_ip,
    input  logic                      ckpt_en,
    input  logic [$clog2(CKPT_N)-1:0] ckpt_tag,
    input  logic                      restore_en,
    input  logic [$clog2(CKPT_N)-1:0] restore_tag,
    output logic [IP_WIDTH-1:0]       pred_ip,
    output logic                      pred_valid,
    output logic                      empty,
    output logic                      ovf
);

    import ret_addr_stack_pkg::*;

    localparam int TW = $clog2(DEPTH);
    localparam int CW = TW + 1;

    logic [IP_WIDTH-1:0] entries [DEPTH];
    logic [TW-1:0]       tos, tosNext;
    logic [CW-1:0]       count, countNext;
    logic                ovfNext, predValidNext, predLoad;
    logic                memWe;
    logic [TW-1:0]       memAddr;
    logic [IP_WIDTH-1:0] memData;
    logic                isFull, isEmpty;

    assign isEmpty = (count == '0);
    assign isFull  = (count == CW'(DEPTH));
    assign empty   = isEmpty;

`ifdef RAS_CHECKPOINT_EN
    ras_ckpt_t ckptWrData, restoreSlot;

    assign ckptWrData = '{tos: tos, count: count, top_ip: entries[tos]};

    ras_ckpt_table #(.CKPT_N(CKPT_N)) ckptTable (
        .clk    (clk),
        .wrEn   (ckpt_en),
        .wrTag  (ckpt_tag),
        .wrData (ckptWrData),
        .rdTag  (restore_tag),
        .rdData (restoreSlot)
    );
`else
    logic unusedCkpt;
    assign unusedCkpt = ^{ckpt_en, ckpt_tag, restore_tag};
`endif

    // Restore wins; a push+pop pair swaps the top entry in place.
    always_comb begin
        tosNext       = tos;
        countNext     = count;
        ovfNext       = ovf;
        predValidNext = 1'b0;
        predLoad      = 1'b0;
        memWe         = 1'b0;
        memAddr       = tos + 1'b1;
        memData       = push_ip;
        if (restore_en) begin
`ifdef RAS_CHECKPOINT_EN
            tosNext   = restoreSlot.tos;
            countNext = restoreSlot.count;
            memWe     = 1'b1;
            memAddr   = restoreSlot.tos;
            memData   = restoreSlot.top_ip;
`else
            tosNext   = '0;
            countNext = '0;
`endif
            ovfNext = 1'b0;
        end else if (push_en && pop_en && !isEmpty) begin
            predLoad      = 1'b1;
            predValidNext = 1'b1;
            memWe         = 1'b1;
            memAddr       = tos;
        end else if (push_en) begin
            tosNext = tos + 1'b1;
            memWe   = 1'b1;
            if (isFull) begin
                ovfNext = 1'b1;
            end else begin
                countNext = count + 1'b1;
            end
        end else if (pop_en && !isEmpty) begin
            predLoad      = 1'b1;
            predValidNext = 1'b1;
            tosNext       = tos - 1'b1;
            countNext     = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            pred_valid <= 1'b0;
            pred_ip    <= '0;
        end else begin
            tos        <= tosNext;
            count      <= countNext;
            ovf        <= ovfNext;
            pred_valid <= predValidNext;
            if (predLoad) begin
                pred_ip <= entries[tos];
            end
        end
    end

    // Entry storage carries no reset; count gates what is ever read out.
    always_ff @(posedge clk) begin
        if (memWe) begin
            entries[memAddr] <= memData;
        end
    end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Self-checking bench for ret_addr_stack: directed scenarios plus random traffic
// against an array-based stack model. Honours RAS_CHECKPOINT_EN when defined.
module tb_ret_addr_stack;

    localparam int DEPTH  = 16;
    localparam int IPW    = 48;
    localparam int CKPT_N = 8;
    localparam int TAGW   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pushEn = 1'b0, popEn = 1'b0, ckptEn = 1'b0, restoreEn = 1'b0;
    logic [IPW-1:0]  pushIp = '0;
    logic [TAGW-1:0] ckptTag = '0, restoreTag = '0;
    logic [IPW-1:0]  predIp;
    logic            predValid, empty, ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: plain stack held as a ring array with top index and size.
    logic [IPW-1:0] mMem [DEPTH];
    int             mTos, mCount;
    bit             mOvf, mPredValid;
    logic [IPW-1:0] mPredIp;
`ifdef RAS_CHECKPOINT_EN
    int             slotTos [CKPT_N];
    int             slotCount [CKPT_N];
    logic [IPW-1:0] slotTop [CKPT_N];
    bit             slotValid [CKPT_N];
`endif

    always #5 clk = ~clk;

    ret_addr_stack #(.DEPTH(DEPTH), .IP_WIDTH(IPW), .CKPT_N(CKPT_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_en     (pushEn),
        .pop_en      (popEn),
        .push_ip     (pushIp),
        .ckpt_en     (ckptEn),
        .ckpt_tag    (ckptTag),
        .restore_en  (restoreEn),
        .restore_tag (restoreTag),
        .pred_ip     (predIp),
        .pred_valid  (predValid),
        .empty       (empty),
        .ovf         (ovf)
    );

    function automatic void modelReset();
        mTos       = 0;
        mCount     = 0;
        mOvf       = 0;
        mPredValid = 0;
        mPredIp    = '0;
    endfunction

    function automatic void modelStep(bit pu, bit po, logic [IPW-1:0] ip, bit ck, int ct, bit re, int rt);
`ifdef RAS_CHECKPOINT_EN
        int             rTos   = slotTos[rt];
        int             rCount = slotCount[rt];
        logic [IPW-1:0] rTop   = slotTop[rt];
        if (ck) begin
            slotTos[ct]   = mTos;
            slotCount[ct] = mCount;
            slotTop[ct]   = mMem[mTos];
            slotValid[ct] = 1;
        end
`endif
        if (re) begin
`ifdef RAS_CHECKPOINT_EN
            mTos       = rTos;
            mCount     = rCount;
            mMem[rTos] = rTop;
`else
            mTos   = 0;
            mCount = 0;
`endif
            mOvf       = 0;
            mPredValid = 0;
        end else if (pu && po && mCount > 0) begin
            mPredIp    = mMem[mTos];
            mPredValid = 1;
            mMem[mTos] = ip;
        end else if (pu) begin
            mTos       = (mTos + 1) % DEPTH;
            mMem[mTos] = ip;
            if (mCount == DEPTH) mOvf = 1;
            else mCount++;
            mPredValid = 0;
        end else if (po && mCount > 0) begin
            mPredIp    = mMem[mTos];
            mPredValid = 1;
            mTos       = (mTos + DEPTH - 1) % DEPTH;
            mCount--;
        end else begin
            mPredValid = 0;
        end
    endfunction

    task automatic applyStimulus(input bit pu, input bit po, input logic [IPW-1:0] ip,
                                 input bit ck, input int ct, input bit re, input int rt);
        @(negedge clk);
        pushEn     = pu;
        popEn      = po;
        pushIp     = ip;
        ckptEn     = ck;
        ckptTag    = TAGW'(ct);
        restoreEn  = re;
        restoreTag = TAGW'(rt);
        @(posedge clk);
        modelStep(pu, po, ip, ck, ct, re, rt);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        pushEn = 0; popEn = 0; ckptEn = 0; restoreEn = 0;
        rst = 0;
        modelReset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0;
        modelReset();
        #1;
        checks++;
        if (predValid !== 1'b0 || predIp !== '0 || empty !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%b ip=%h empty=%b ovf=%b required 0 0 1 0",
                     predValid, predIp, empty, ovf);
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_lifo();
        logic [IPW-1:0] expIp [3];
        expIp = '{48'h3000, 48'h2000, 48'h1000};
        doReset();
        applyStimulus(1, 0, 48'h1000, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'h2000, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'h3000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, '0, 0, 0, 0, 0);
            checks++;
            if (predValid !== 1'b1 || predIp !== expIp[i]) begin
                errors++;
                $display("[TB] FAIL lifo_pop%0d: got valid=%b ip=%h required 1 %h", i, predValid, predIp, expIp[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lifo_empty: got %b required 1", empty);
        end
        applyStimulus(0, 0, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lifo_pulse: got valid=%b required 0", predValid);
        end
    endtask

    task automatic test_overflow();
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 0, IPW'(48'h10 + i), 0, 0, 0, 0);
            if (i == 15) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_at_full: got %b required 0", ovf);
                end
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_after_wrap: got %b required 1", ovf);
        end
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 1, '0, 0, 0, 0, 0);
            checks++;
            if (predValid !== 1'b1 || predIp !== IPW'(48'h20 - k)) begin
                errors++;
                $display("[TB] FAIL ovf_pop%0d: got valid=%b ip=%h required 1 %h", k, predValid, predIp, 48'h20 - k);
            end
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b0 || empty !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_extra_pop: got valid=%b empty=%b ovf=%b required 0 1 1", predValid, empty, ovf);
        end
    endtask

    task automatic test_push_pop();
        doReset();
        applyStimulus(1, 0, 48'h100, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'h200, 0, 0, 0, 0);
        applyStimulus(1, 1, 48'h300, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b1 || predIp !== 48'h200) begin
            errors++;
            $display("[TB] FAIL swap_out: got valid=%b ip=%h required 1 200", predValid, predIp);
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b1 || predIp !== 48'h300) begin
            errors++;
            $display("[TB] FAIL swap_next: got valid=%b ip=%h required 1 300", predValid, predIp);
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predIp !== 48'h100 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL swap_depth: got ip=%h empty=%b required 100 1", predIp, empty);
        end
        applyStimulus(1, 1, 48'h77, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b0 || empty !== 1'b0 || predIp !== 48'h100) begin
            errors++;
            $display("[TB] FAIL swap_on_empty: got valid=%b empty=%b ip=%h required 0 0 100", predValid, empty, predIp);
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b1 || predIp !== 48'h77) begin
            errors++;
            $display("[TB] FAIL swap_on_empty_pop: got valid=%b ip=%h required 1 77", predValid, predIp);
        end
    endtask

`ifdef RAS_CHECKPOINT_EN
    task automatic test_restore();
        logic [IPW-1:0] expIp [2];
        expIp = '{48'hB0, 48'hA0};
        doReset();
        applyStimulus(1, 0, 48'hA0, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'hB0, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 3, 0, 0);
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'hC0, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'hDD, 0, 0, 1, 3);
        checks++;
        if (predValid !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restore_state: got valid=%b empty=%b required 0 0", predValid, empty);
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b1 || predIp !== 48'hB0) begin
            errors++;
            $display("[TB] FAIL restore_top: got valid=%b ip=%h required 1 b0", predValid, predIp);
        end
        // Only the top entry is snapshotted; the slot under it was reused by the C0 push.
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b1 || predIp !== mPredIp) begin
            errors++;
            $display("[TB] FAIL restore_second: got valid=%b ip=%h required 1 %h", predValid, predIp, mPredIp);
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restore_count: got valid=%b empty=%b required 0 1", predValid, empty);
        end
        doReset();
        applyStimulus(1, 0, 48'hA0, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'hB0, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 5, 0, 0);
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'hC0, 0, 0, 0, 0);
        applyStimulus(1, 0, 48'hEE, 0, 0, 1, 5);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, '0, 0, 0, 0, 0);
            checks++;
            if (predValid !== 1'b1 || predIp !== expIp[i]) begin
                errors++;
                $display("[TB] FAIL restore_pop%0d: got valid=%b ip=%h required 1 %h", i, predValid, predIp, expIp[i]);
            end
        end
    endtask
`else
    task automatic test_restore();
        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(1, 0, IPW'(48'h40 + i), 0, 0, 0, 0);
        applyStimulus(1, 0, 48'h99, 0, 0, 1, 2);
        checks++;
        if (predValid !== 1'b0 || empty !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_state: got valid=%b empty=%b ovf=%b required 0 1 0", predValid, empty, ovf);
        end
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_pop: got valid=%b required 0", predValid);
        end
    endtask
`endif

    task automatic test_reset_mid_pop();
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, IPW'(48'h500 + i), 0, 0, 0, 0);
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        @(negedge clk);
        popEn = 1;
        #2;
        rst = 0;
        #1;
        checks++;
        if (predValid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_pop: got valid=%b empty=%b required 0 1", predValid, empty);
        end
        @(negedge clk);
        popEn = 0;
        modelReset();
        rst = 1;
        applyStimulus(1, 0, 48'h55, 0, 0, 0, 0);
        applyStimulus(0, 1, '0, 0, 0, 0, 0);
        checks++;
        if (predValid !== 1'b1 || predIp !== 48'h55) begin
            errors++;
            $display("[TB] FAIL after_reset_pop: got valid=%b ip=%h required 1 55", predValid, predIp);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int n = 0; n < 400; n++) begin
            int             r  = int'($urandom_range(0, 99));
            bit             pu = (r < 40) || (r >= 75 && r < 85);
            bit             po = (r >= 40 && r < 85);
            bit             ck = ($urandom_range(0, 99) < 15);
            int             ct = int'($urandom_range(0, CKPT_N - 1));
            int             rt = int'($urandom_range(0, CKPT_N - 1));
            bit             re = ($urandom_range(0, 99) < 6);
            logic [IPW-1:0] ip = {16'($urandom), 32'($urandom)};
`ifdef RAS_CHECKPOINT_EN
            if (!slotValid[rt]) re = 0;
`endif
            applyStimulus(pu, po, ip, ck, ct, re, rt);
            checks++;
            if (predValid !== mPredValid || predIp !== mPredIp || empty !== (mCount == 0) || ovf !== mOvf) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got valid=%b ip=%h empty=%b ovf=%b required %b %h %b %b",
                         n, predValid, predIp, empty, ovf, mPredValid, mPredIp, (mCount == 0), mOvf);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        test_reset();
        test_lifo();
        test_overflow();
        test_push_pop();
        test_restore();
        test_reset_mid_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
